node_activity_monitor: RTL and testbench
========================================

// Module: node_activity_monitor
// PURPOSE
//   Downstream observer for one extracted Nt-node subcircuit output.
//   Samples that single-bit node over a programmable window and counts:
//     - value toggles
//     - occurrences of a designated "rare" value
//   Raises a trojan-trigger-candidate alarm when the rare count stays at or below a threshold.
//   Publishes one result record per window over a valid/ready handshake to the detection-data collector.
// PARAMETERS
//   WIN_W   16  width of window-length and sample counters
//   CNT_W   16  width of toggle/rare counters (saturating)
// PORTS
//   CLK          in   1       single clock; all logic on rising edge
//   RST          in   1       reset: synchronous, active-high
//   start        in   1       pulse: begin a window (honoured in IDLE only)
//   win_len      in   WIN_W   number of valid samples in window; captured on start
//   rare_val     in   1       node value treated as rare; captured on start
//   rare_thresh  in   CNT_W   alarm threshold; captured on start
//   node_in      in   1       observed subcircuit output node
//   node_valid   in   1       node_in is a valid sample this cycle
//   busy         out  1       high in RUN and REPORT
//   rpt_valid    out  1       result record valid
//   rpt_ready    in   1       collector accepts record
//   toggle_cnt   out  CNT_W   toggles between consecutive valid samples
//   rare_cnt     out  CNT_W   valid samples equal to rare_val
//   alarm        out  1       rare_cnt <= rare_thresh, valid with rpt_valid
// BEHAVIOUR
//   Reset (RST=1 at edge)
//     - state=IDLE
//     - busy, rpt_valid, alarm, toggle_cnt, rare_cnt, sample counter, have_prev all 0
//     - RST has priority over every other input, in any state, including mid-window and mid-report
//   FSM: IDLE -> RUN -> REPORT -> IDLE
//   IDLE
//     - start=1 and win_len!=0: capture win_len/rare_val/rare_thresh; clear counters and have_prev; go to RUN
//     - start=1 and win_len==0: ignored; stay in IDLE
//   RUN (each cycle with node_valid=1)
//     - samp_cnt += 1
//     - if have_prev and node_in != prev: toggle_cnt += 1
//     - if node_in == rare_val: rare_cnt += 1
//     - prev <= node_in; have_prev <= 1
//     - first sample of a window never counts as a toggle
//     - node_valid=0 cycles change nothing
//   Saturation: toggle_cnt and rare_cnt hold at 2^CNT_W-1; no wrap.
//   Window end
//     - the edge that consumes sample number win_len moves state to REPORT
//     - rpt_valid=1 and alarm=(rare_cnt<=rare_thresh) in the following cycle
//     - latency: 1 cycle from last sample to rpt_valid
//   REPORT
//     - rpt_valid, toggle_cnt, rare_cnt, alarm held stable until rpt_valid&rpt_ready
//     - node_valid samples are ignored
//     - handshake edge: go to IDLE; rpt_valid and alarm drop next cycle; counts retain last values
//   start is ignored while busy, including a start coincident with the handshake edge; a new window requires start in IDLE.
//   win_len/rare_val/rare_thresh changes after capture have no effect on the running window.
// TESTING
//   T1
//     - stimulus: reset held 3 cycles
//     - required: all outputs 0, busy=0; start pulses during reset ignored
//   T2
//     - stimulus: win_len=8, rare_val=1, thresh=2; node 0,1,0,0,1,1,0,0 on consecutive valid cycles
//     - required: toggle_cnt=4, rare_cnt=3, alarm=0; rpt_valid exactly 1 cycle after 8th sample
//   T3
//     - stimulus: win_len=5, rare_val=1, thresh=1, node constant 0 with node_valid gaps
//     - required: toggle_cnt=0, rare_cnt=0, alarm=1; gaps do not advance window
//   T4
//     - stimulus: CNT_W=4, win_len=40, alternating node
//     - required: toggle_cnt=15, rare_cnt=15 (saturated), no wrap
//   T5
//     - stimulus: rpt_ready low 10 cycles in REPORT while node toggles and start pulses
//     - required: record unchanged; single handshake returns to IDLE; start on that edge ignored
//   T6
//     - stimulus: RST asserted at sample 3 of 8, then start with win_len=0
//     - required: IDLE with zeroed outputs; zero-length start ignored, busy stays 0

Source files
------------

// File: rtl/node_activity_monitor.sv
// Observes one subcircuit node over a programmed window of valid samples,
// counts toggles and rare-value hits, and reports one record per window.
module node_activity_monitor #(
    parameter int WIN_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             rare_val,
    input  logic [CNT_W-1:0] rare_thresh,
    input  logic             node_in,
    input  logic             node_valid,
    output logic             busy,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [CNT_W-1:0] rare_cnt,
    output logic             alarm
);

    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

    state_t           state, state_nx;
    logic [WIN_W-1:0] win_len_q;
    logic [WIN_W-1:0] samp_cnt;
    logic [CNT_W-1:0] thresh_q;
    logic             rare_val_q;
    logic             prev;
    logic             have_prev;

    logic launch;
    logic sample_ok;
    logic last_sample;

    assign launch      = (state == IDLE) && start && (win_len != '0);
    assign sample_ok   = (state == RUN) && node_valid;
    // samp_cnt never exceeds win_len_q-1 in RUN, so the increment cannot wrap.
    assign last_sample = sample_ok && (WIN_W'(samp_cnt + 1'b1) == win_len_q);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (launch)      state_nx = RUN;
            RUN:     if (last_sample) state_nx = REPORT;
            REPORT:  if (rpt_ready)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            win_len_q  <= '0;
            samp_cnt   <= '0;
            thresh_q   <= '0;
            rare_val_q <= 1'b0;
            prev       <= 1'b0;
            have_prev  <= 1'b0;
            toggle_cnt <= '0;
            rare_cnt   <= '0;
        end else if (launch) begin
            win_len_q  <= win_len;
            rare_val_q <= rare_val;
            thresh_q   <= rare_thresh;
            samp_cnt   <= '0;
            have_prev  <= 1'b0;
            toggle_cnt <= '0;
            rare_cnt   <= '0;
        end else if (sample_ok) begin
            samp_cnt  <= samp_cnt + 1'b1;
            prev      <= node_in;
            have_prev <= 1'b1;
            if (have_prev && (node_in != prev) && (toggle_cnt != '1))
                toggle_cnt <= toggle_cnt + 1'b1;
            if ((node_in == rare_val_q) && (rare_cnt != '1))
                rare_cnt <= rare_cnt + 1'b1;
        end
    end

    // Counts are frozen in REPORT, so a combinational compare stays stable.
    assign busy      = (state != IDLE);
    assign rpt_valid = (state == REPORT);
    assign alarm     = (state == REPORT) && (rare_cnt <= thresh_q);

endmodule

// File: tb/tb_node_activity_monitor.sv
// Randomized bench for node_activity_monitor; expected records come from
// counting over the driven sample list.
module tb_node_activity_monitor;
    localparam int WIN_W = 16;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             start = 1'b0;
    logic [WIN_W-1:0] win_len = '0;
    logic             rare_val = 1'b0;
    logic [CNT_W-1:0] rare_thresh = '0;
    logic             node_in = 1'b0;
    logic             node_valid = 1'b0;
    logic             busy, rpt_valid, alarm;
    logic             rpt_ready = 1'b0;
    logic [CNT_W-1:0] toggle_cnt, rare_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    bit seq[$];

    node_activity_monitor #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .win_len(win_len),
        .rare_val(rare_val), .rare_thresh(rare_thresh), .node_in(node_in),
        .node_valid(node_valid), .busy(busy), .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready), .toggle_cnt(toggle_cnt), .rare_cnt(rare_cnt),
        .alarm(alarm)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_rpt"},   int'(rpt_valid), 0);
        chk({tag, "_alarm"}, int'(alarm), 0);
        chk({tag, "_tog"},   int'(toggle_cnt), 0);
        chk({tag, "_rare"},  int'(rare_cnt), 0);
    endtask

    // Drive one complete window from seq[], then hold in REPORT and handshake.
    task automatic run_window(input bit rv, input int th, input int gap_pct, input int hold);
        int  len, tog, rar, ex_al;
        len = seq.size();
        tog = 0;
        rar = 0;
        foreach (seq[i]) begin
            if (i > 0 && seq[i] != seq[i-1]) tog++;
            if (seq[i] == rv) rar++;
        end
        if (tog > SAT) tog = SAT;
        if (rar > SAT) rar = SAT;
        ex_al = (rar <= th) ? 1 : 0;

        @(negedge CLK);
        chk("idle_busy", int'(busy), 0);
        start = 1'b1; win_len = WIN_W'(len); rare_val = rv; rare_thresh = CNT_W'(th);
        @(negedge CLK);
        start = 1'b0;
        chk("run_busy", int'(busy), 1);
        // Configuration changes after capture must not affect this window.
        win_len = WIN_W'($urandom_range(1, 3)); rare_val = ~rv; rare_thresh = CNT_W'($urandom);
        for (int i = 0; i < len; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                node_valid = 1'b0; node_in = 1'($urandom);
                @(negedge CLK);
                chk("gap_no_rpt", int'(rpt_valid), 0);
            end
            node_valid = 1'b1; node_in = seq[i];
            @(negedge CLK);
            if (i != len - 1) chk("run_no_rpt", int'(rpt_valid), 0);
        end
        node_valid = 1'b0;
        chk("rpt_latency", int'(rpt_valid), 1);
        chk("rpt_tog",     int'(toggle_cnt), tog);
        chk("rpt_rare",    int'(rare_cnt), rar);
        chk("rpt_alarm",   int'(alarm), ex_al);
        for (int h = 0; h < hold; h++) begin
            node_valid = 1'($urandom); node_in = 1'($urandom); start = 1'($urandom);
            @(negedge CLK);
            chk("hold_rpt",   int'(rpt_valid), 1);
            chk("hold_tog",   int'(toggle_cnt), tog);
            chk("hold_rare",  int'(rare_cnt), rar);
            chk("hold_alarm", int'(alarm), ex_al);
        end
        rpt_ready = 1'b1; start = 1'b1; win_len = 16'd4; node_valid = 1'b1; node_in = 1'($urandom);
        @(negedge CLK);
        rpt_ready = 1'b0; start = 1'b0; node_valid = 1'b0;
        chk("hs_busy",  int'(busy), 0);
        chk("hs_rpt",   int'(rpt_valid), 0);
        chk("hs_alarm", int'(alarm), 0);
        chk("hs_tog",   int'(toggle_cnt), tog);
        chk("hs_rare",  int'(rare_cnt), rar);
        @(negedge CLK);
        chk("hs_start_ignored", int'(busy), 0);
    endtask

    initial begin
        // T1: reset held 3 cycles with start pulses
        win_len = 16'd5;
        for (int i = 0; i < 3; i++) begin
            start = 1'(i % 2 == 0);
            @(negedge CLK);
            chk_zero("reset");
        end
        RST = 1'b0; start = 1'b0;
        @(negedge CLK);
        chk_zero("post_reset");

        // T2: fixed pattern, no gaps
        seq = '{0, 1, 0, 0, 1, 1, 0, 0};
        run_window(1'b1, 2, 0, 0);

        // T3: constant zero with gaps
        seq = '{0, 0, 0, 0, 0};
        run_window(1'b1, 1, 40, 0);

        // T4: alternating 40 samples, both counters saturate
        seq.delete();
        for (int i = 0; i < 40; i++) seq.push_back(1'(i % 2 == 0));
        run_window(1'b1, 3, 0, 0);

        // T5: long REPORT stall with activity and start pulses
        seq.delete();
        for (int i = 0; i < 6; i++) seq.push_back(1'($urandom));
        run_window(1'b0, 2, 20, 10);

        // T6: reset mid-window, then zero-length start
        @(negedge CLK);
        start = 1'b1; win_len = 16'd8; rare_val = 1'b1; rare_thresh = 4'd5;
        @(negedge CLK);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            node_valid = 1'b1; node_in = 1'(i % 2);
            if (i == 2) RST = 1'b1;
            @(negedge CLK);
        end
        node_valid = 1'b0; RST = 1'b0;
        chk_zero("mid_reset");
        start = 1'b1; win_len = '0;
        @(negedge CLK);
        start = 1'b0;
        chk("zero_len_busy", int'(busy), 0);
        @(negedge CLK);
        chk("zero_len_busy2", int'(busy), 0);
        chk("zero_len_rpt",   int'(rpt_valid), 0);

        // Random windows
        for (int w = 0; w < 20; w++) begin
            int len;
            len = $urandom_range(1, 40);
            seq.delete();
            for (int i = 0; i < len; i++) seq.push_back(1'($urandom));
            run_window(1'($urandom), int'($urandom_range(0, SAT)),
                       int'($urandom_range(0, 50)), int'($urandom_range(0, 4)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
